// File: rtl/otp_zeroize_checker.sv
// Zeroization read-back verifier: reads each 64-bit block of a range, checks its popcount
// and classifies the run. Optional run statistics are built when OTP_ZEROIZE_CHECK_STATS_EN is defined.
module otp_zeroize_checker #(
   parameter int AddrWidth   = 14,
   parameter int NumBlkWidth = 8,
   parameter int ValidBound  = 56,
   parameter int FatalBound  = 48
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [AddrWidth-1:0]   base_addr_i,
   input  logic [NumBlkWidth-1:0] num_blk_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [1:0]             result_o,
   output logic [2:0]             err_code_o,
   output logic [AddrWidth-1:0]   bad_addr_o,
`ifdef OTP_ZEROIZE_CHECK_STATS_EN
   output logic [6:0]             min_pop_o,
   output logic [NumBlkWidth-1:0] indet_cnt_o,
`endif
   output logic                   otp_valid_o,
   input  logic                   otp_ready_i,
   output logic [2:0]             otp_cmd_o,
   output logic [1:0]             otp_size_o,
   output logic [AddrWidth-2:0]   otp_addr_o,
   input  logic                   otp_rvalid_i,
   input  logic [63:0]            otp_rdata_i,
   input  logic [2:0]             otp_err_i
);

   localparam logic [2:0] CmdRead           = 3'b000;
   localparam logic [2:0] NoError           = 3'h0;
   localparam logic [2:0] MacroEccCorrError = 3'h2;
   localparam logic [2:0] AccessError       = 3'h5;
   localparam logic [1:0] ResValid = 2'd0, ResIndet = 2'd1, ResFatal = 2'd2, ResError = 2'd3;
   localparam logic [6:0] FatalPop = 7'(FatalBound);
   localparam logic [6:0] ValidPop = 7'(ValidBound);
   localparam logic [NumBlkWidth-1:0] OneBlk = NumBlkWidth'(1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DONE} state_e;

   state_e                 state_reg;
   logic [AddrWidth-1:0]   addr_reg;
   logic [NumBlkWidth-1:0] remain_reg;
   logic [63:0]            data_reg;
   logic                   busy_reg, done_reg, valid_reg, bad_set_reg;
   logic [1:0]             result_reg;
   logic [2:0]             err_code_reg;
   logic [AddrWidth-1:0]   bad_addr_reg;
   logic [AddrWidth:0]     addr_sum;
   logic [3:0]             byte_pop [8];
   logic [6:0]             pop;

   // Per-byte counts keep the adder tree shallow ahead of the CHECK compare.
   for (genvar gi = 0; gi < 8; gi++) begin : g_byte_pop
      assign byte_pop[gi] = 4'($countones(data_reg[gi*8 +: 8]));
   end

   always_comb begin
      pop = 7'd0;
      for (int i = 0; i < 8; i++) begin
         pop = pop + 7'(byte_pop[i]);
      end
   end

   assign addr_sum = {1'b0, addr_reg} + (AddrWidth+1)'(8);

`ifdef OTP_ZEROIZE_CHECK_STATS_EN
   logic [6:0]             min_pop_reg;
   logic [NumBlkWidth-1:0] indet_cnt_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_pop_reg   <= 7'd0;
         indet_cnt_reg <= '0;
      end else if (state_reg == IDLE && start_i) begin
         min_pop_reg   <= 7'd64;
         indet_cnt_reg <= '0;
      end else if (state_reg == CHECK) begin
         if (pop < min_pop_reg) min_pop_reg <= pop;
         if (pop >= FatalPop && pop < ValidPop && indet_cnt_reg != '1)
            indet_cnt_reg <= indet_cnt_reg + OneBlk;
      end
   end

   assign min_pop_o   = min_pop_reg;
   assign indet_cnt_o = indet_cnt_reg;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         remain_reg   <= '0;
         data_reg     <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         bad_set_reg  <= 1'b0;
         result_reg   <= ResValid;
         err_code_reg <= NoError;
         bad_addr_reg <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: if (start_i) begin
               addr_reg     <= base_addr_i;
               remain_reg   <= num_blk_i;
               result_reg   <= ResValid;
               err_code_reg <= NoError;
               bad_addr_reg <= '0;
               bad_set_reg  <= 1'b0;
               if (base_addr_i[2:0] != 3'b000) begin
                  result_reg   <= ResError;
                  err_code_reg <= AccessError;
                  state_reg    <= DONE;
                  done_reg     <= 1'b1;
               end else if (num_blk_i == '0) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg <= REQ;
                  busy_reg  <= 1'b1;
                  valid_reg <= 1'b1;
               end
            end
            REQ: if (otp_ready_i) begin
               valid_reg <= 1'b0;
               state_reg <= WAIT;
            end
            WAIT: if (otp_rvalid_i) begin
               data_reg <= otp_rdata_i;
               if (otp_err_i == NoError || otp_err_i == MacroEccCorrError) begin
                  state_reg <= CHECK;
               end else begin
                  result_reg   <= ResError;
                  err_code_reg <= otp_err_i;
                  bad_addr_reg <= addr_reg;
                  bad_set_reg  <= 1'b1;
                  state_reg    <= DONE;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
               end
            end
            CHECK: begin
               if (pop < FatalPop) begin
                  result_reg <= ResFatal;
                  if (!bad_set_reg) bad_addr_reg <= addr_reg;
                  bad_set_reg <= 1'b1;
                  state_reg   <= DONE;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
               end else begin
                  if (pop < ValidPop) begin
                     if (result_reg == ResValid) result_reg <= ResIndet;
                     if (!bad_set_reg) begin
                        bad_addr_reg <= addr_reg;
                        bad_set_reg  <= 1'b1;
                     end
                  end
                  remain_reg <= remain_reg - OneBlk;
                  addr_reg   <= addr_sum[AddrWidth-1:0];
                  if (remain_reg == OneBlk) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else if (addr_sum[AddrWidth]) begin
                     // Range ran off the top of the address space with blocks still pending.
                     result_reg   <= ResError;
                     err_code_reg <= AccessError;
                     state_reg    <= DONE;
                     busy_reg     <= 1'b0;
                     done_reg     <= 1'b1;
                  end else begin
                     state_reg <= REQ;
                     valid_reg <= 1'b1;
                  end
               end
            end
            DONE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_reg;
   assign done_o      = done_reg;
   assign result_o    = result_reg;
   assign err_code_o  = err_code_reg;
   assign bad_addr_o  = bad_addr_reg;
   assign otp_valid_o = valid_reg;
   assign otp_cmd_o   = CmdRead;
   assign otp_size_o  = 2'd3;
   assign otp_addr_o  = addr_reg[AddrWidth-1:1];

endmodule

// File: tb/tb_otp_zeroize_checker.sv
// Scoreboard bench for otp_zeroize_checker: a per-run reference model predicts requests and the
// final classification; a macro responder and a done monitor check the DUT independently.
module tb_otp_zeroize_checker;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [13:0] base_addr_i = '0;
   logic [7:0]  num_blk_i = '0;
   logic        busy_o, done_o;
   logic [1:0]  result_o;
   logic [2:0]  err_code_o;
   logic [13:0] bad_addr_o;
   logic        otp_valid_o;
   logic        otp_ready_i = 1'b1;
   logic [2:0]  otp_cmd_o;
   logic [1:0]  otp_size_o;
   logic [12:0] otp_addr_o;
   logic        otp_rvalid_i = 1'b0;
   logic [63:0] otp_rdata_i = '0;
   logic [2:0]  otp_err_i = '0;
`ifdef OTP_ZEROIZE_CHECK_STATS_EN
   logic [6:0]  min_pop_o;
   logic [7:0]  indet_cnt_o;
`endif

   otp_zeroize_checker dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .base_addr_i(base_addr_i), .num_blk_i(num_blk_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
      .err_code_o(err_code_o), .bad_addr_o(bad_addr_o),
`ifdef OTP_ZEROIZE_CHECK_STATS_EN
      .min_pop_o(min_pop_o), .indet_cnt_o(indet_cnt_o),
`endif
      .otp_valid_o(otp_valid_o), .otp_ready_i(otp_ready_i),
      .otp_cmd_o(otp_cmd_o), .otp_size_o(otp_size_o), .otp_addr_o(otp_addr_o),
      .otp_rvalid_i(otp_rvalid_i), .otp_rdata_i(otp_rdata_i), .otp_err_i(otp_err_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int result;
      int err;
      int bad;
      int lat;
      bit chk_lat;
      int start_cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          addr_q[$];
   logic [63:0] rdata_q[$];
   logic [2:0]  rerr_q[$];
   int          blk_pop [256];
   int          blk_err [256];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int run_id = 0;
   bit manual = 1'b0;
   bit stall_mode = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [63:0] make_word(input int k);
      logic [63:0] w = '1;
      while ($countones(w) > k) w[$urandom_range(0, 63)] = 1'b0;
      return w;
   endfunction

   // Reference model: walks the range block by block using the classification rules.
   task automatic build_run(input int base, input int num, input bit chk);
      exp_t e;
      bit   bad_set = 1'b0;
      e.result = 0; e.err = 0; e.bad = 0; e.lat = 1; e.chk_lat = chk; e.start_cyc = cyc;
      if (base % 8 != 0) begin
         e.result = 3; e.err = 5;
      end else if (num != 0) begin
         e.lat = 1 + 3 * num;
         for (int k = 0; k < num; k++) begin
            int a = base + 8 * k;
            if (a >= 16384) begin
               e.result = 3; e.err = 5; e.lat = 1 + 3 * k;
               break;
            end
            addr_q.push_back(a / 2);
            rdata_q.push_back(make_word(blk_pop[k]));
            rerr_q.push_back(3'(blk_err[k]));
            if (blk_err[k] != 0 && blk_err[k] != 2) begin
               e.result = 3; e.err = blk_err[k]; e.bad = a; e.lat = 3 + 3 * k;
               break;
            end
            if (blk_pop[k] < 48) begin
               e.result = 2;
               if (!bad_set) e.bad = a;
               e.lat = 4 + 3 * k;
               break;
            end
            if (blk_pop[k] < 56) begin
               if (e.result < 1) e.result = 1;
               if (!bad_set) begin
                  e.bad = a;
                  bad_set = 1'b1;
               end
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // Macro responder: checks each accepted request address and answers one cycle later.
   initial begin
      bit fire = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!manual) begin
            otp_rvalid_i = 1'b0;
            if (fire) begin
               fire = 1'b0;
               otp_rvalid_i = 1'b1;
               otp_rdata_i = (rdata_q.size() > 0) ? rdata_q.pop_front() : '1;
               otp_err_i   = (rerr_q.size() > 0) ? rerr_q.pop_front() : 3'd0;
            end
            otp_ready_i = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (otp_valid_o && otp_ready_i && !rst_i) begin
               fire = 1'b1;
               if (addr_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_req actual_addr=%0h required=none", otp_addr_o);
               end else begin
                  check("req_addr", int'(otp_addr_o), addr_q.pop_front());
                  check("req_cmd", int'(otp_cmd_o), 0);
                  check("req_size", int'(otp_size_o), 3);
               end
            end
         end
      end
   end

   // Done monitor: compares the DUT's run summary with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               run_id++;
               check("result", int'(result_o), e.result);
               check("err_code", int'(err_code_o), e.err);
               check("bad_addr", int'(bad_addr_o), e.bad);
               check("busy_at_done", int'(busy_o), 0);
               check("pending_reqs", addr_q.size(), 0);
               if (e.chk_lat) check("latency", cyc - e.start_cyc, e.lat);
               $display("run %0d: result=%0d err=%0d bad_addr=%0h cycles=%0d",
                        run_id, result_o, err_code_o, bad_addr_o, cyc - e.start_cyc);
            end
         end
      end
   end

   task automatic do_run(input int base, input int num, input bit stall);
      int t = 0;
      stall_mode = stall;
      @(negedge clk_i);
      base_addr_i = 14'(base);
      num_blk_i   = 8'(num);
      start_i     = 1'b1;
      build_run(base, num, !stall);
      @(negedge clk_i);
      start_i = 1'b0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      check("done_timeout", exp_q.size(), 0);
      if (exp_q.size() != 0) begin
         exp_q.delete(); addr_q.delete(); rdata_q.delete(); rerr_q.delete();
         rst_i = 1'b1;
         @(negedge clk_i);
         rst_i = 1'b0;
      end
      repeat (2) @(negedge clk_i);
   endtask

   task automatic set_blocks(input int p0, input int p1, input int p2, input int e0);
      blk_pop[0] = p0; blk_pop[1] = p1; blk_pop[2] = p2;
      blk_err[0] = e0; blk_err[1] = 0;  blk_err[2] = 0;
   endtask

   initial begin
      int late_done;
      for (int i = 0; i < 256; i++) begin
         blk_pop[i] = 64;
         blk_err[i] = 0;
      end
      repeat (3) @(negedge clk_i);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_valid", int'(otp_valid_o), 0);
      check("rst_result", int'(result_o), 0);
      check("rst_err_code", int'(err_code_o), 0);
      check("rst_bad_addr", int'(bad_addr_o), 0);
      check("cmd_const", int'(otp_cmd_o), 0);
      check("size_const", int'(otp_size_o), 3);
      rst_i = 1'b0;

      set_blocks(64, 64, 64, 0); do_run(14'h040, 2, 1'b0);
      set_blocks(64, 52, 64, 0); do_run(14'h100, 3, 1'b0);
      set_blocks(40, 64, 64, 0); do_run(14'h100, 3, 1'b0);
      set_blocks(64, 64, 64, 3); do_run(14'h100, 3, 1'b0);
      set_blocks(64, 64, 64, 2); do_run(14'h100, 1, 1'b0);
      set_blocks(64, 64, 64, 0); do_run(14'h100, 0, 1'b0);
      set_blocks(64, 64, 64, 0); do_run(14'h104, 2, 1'b0);
      set_blocks(55, 64, 64, 0); do_run(14'h3FF8, 2, 1'b0);
      set_blocks(56, 47, 64, 0); do_run(14'h200, 3, 1'b0);

      // Stalled handshake, then a reset while waiting for data and a stray late response.
      manual = 1'b1;
      otp_ready_i = 1'b0;
      @(negedge clk_i);
      base_addr_i = 14'h200; num_blk_i = 8'd1; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", int'(otp_valid_o), 1);
         check("stall_addr", int'(otp_addr_o), 13'h100);
         @(negedge clk_i);
      end
      otp_ready_i = 1'b1;
      @(negedge clk_i);
      otp_ready_i = 1'b0;
      check("wait_busy", int'(busy_o), 1);
      check("wait_valid", int'(otp_valid_o), 0);
      late_done = done_cnt;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("midrst_busy", int'(busy_o), 0);
      check("midrst_valid", int'(otp_valid_o), 0);
      otp_rvalid_i = 1'b1; otp_rdata_i = '1; otp_err_i = 3'd0;
      @(negedge clk_i);
      otp_rvalid_i = 1'b0;
      repeat (6) @(negedge clk_i);
      check("late_rvalid_done", done_cnt - late_done, 0);
      check("late_rvalid_busy", int'(busy_o), 0);
      manual = 1'b0;
      otp_ready_i = 1'b1;

      for (int r = 0; r < 40; r++) begin
         int base;
         int num = $urandom_range(0, 6);
         for (int k = 0; k < num; k++) begin
            int c = $urandom_range(0, 99);
            int s = $urandom_range(0, 99);
            blk_pop[k] = (c < 70) ? 64 : (c < 80) ? $urandom_range(56, 63) :
                         (c < 92) ? $urandom_range(48, 55) : $urandom_range(0, 47);
            blk_err[k] = (s < 5) ? 2 : (s < 9) ? int'($urandom_range(3, 7)) : (s < 10) ? 1 : 0;
         end
         base = $urandom_range(0, 2047) * 8;
         if ($urandom_range(0, 9) == 0) base = base + $urandom_range(1, 7);
         if ($urandom_range(0, 9) == 0) base = 16384 - 8 * $urandom_range(1, 3);
         do_run(base, num, $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
